ifetch_ctrl: RTL and testbench

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_pkg.sv | 8 +
 rtl/ifetch_buf.sv | 46 ++++
 rtl/ifetch_ctrl.sv | 71 +++++++
 tb/tb_ifetch_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and sizing constants for the instruction fetch controller
package ifetch_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int PC_W       = 10;
  localparam int INST_W     = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int ENTRY_W    = PC_W + INST_W;
endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf: 2-entry {pc, inst} FIFO with push/pop/flush and full/empty flags
module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full  = count_q == CW'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_push = push && !flush && (!full || pop);
    do_pop  = pop && !flush && !empty;
    wr_d    = flush ? '0 : wr_q + PW'(do_push);
    rd_d    = flush ? '0 : rd_q + PW'(do_pop);
    count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // Storage is left unreset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC sequencer feeding a 2-entry fetch buffer; IFETCH_ALIGN_CHECK_EN adds sticky misaligned-redirect fetch_err
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 10'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [PC_W-1:0]   imem_addr,
  output logic [1:0]        imem_word,
  input  logic [63:0]       imem_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_err
`endif
);
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic err_q, err_d;
  logic full, empty, pop, fetch;
  logic [ENTRY_W-1:0] head;
  logic unused;
  assign unused     = ^{imem_data[63:32], redirect_pc[1:0]};
  assign imem_addr  = pc_q;
  assign imem_word  = 2'b00;
  assign inst_valid = !empty;
  assign {inst_pc, inst} = head;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign fetch_err = err_q;
`endif
  always_comb begin
    pop     = !empty && inst_ready && !redirect_valid;
    fetch   = state_q == RUN && !err_q && !redirect_valid && (!full || pop);
    pc_d    = redirect_valid ? {redirect_pc[PC_W-1:2], 2'b00} : fetch ? pc_q + PC_W'(4) : pc_q;
    state_d = run ? RUN : IDLE;
`ifdef IFETCH_ALIGN_CHECK_EN
    err_d   = err_q || (redirect_valid && redirect_pc[1:0] != 2'b00);
`else
    err_d   = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end
  ifetch_buf u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (fetch),
    .pop  (pop),
    .flush(redirect_valid),
    .din  ({pc_q, imem_data[INST_W-1:0]}),
    .dout (head),
    .full (full),
    .empty(empty)
  );
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed scenario tasks for ifetch_ctrl with a combinational instruction memory model
module tb_ifetch_ctrl;
  logic clk = 1'b0;
  logic rst, run, inst_ready, redirect_valid, inst_valid;
  logic [9:0] redirect_pc, imem_addr, inst_pc;
  logic [1:0] imem_word;
  logic [63:0] imem_data;
  logic [31:0] inst;
  logic [31:0] mem [256];
  logic [31:0] prog [4] = '{32'h000010b7, 32'h23408093, 32'h00102023, 32'h00000063};
  int vecs = 0, errs = 0;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic fetch_err;
`endif

  always #5 clk = ~clk;
  assign imem_data = {32'hA5A5_5A5A, mem[imem_addr[9:2]]};

  ifetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .imem_addr     (imem_addr),
    .imem_word     (imem_word),
    .imem_data     (imem_data),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .fetch_err     (fetch_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    vecs++; if (imem_addr !== 10'h000) begin errs++; $display("FAIL reset_addr got %h exp 000", imem_addr); end
    vecs++; if (imem_word !== 2'b00) begin errs++; $display("FAIL reset_word got %b exp 00", imem_word); end
`ifdef IFETCH_ALIGN_CHECK_EN
    vecs++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL reset_err got %b exp 0", fetch_err); end
`endif
  endtask

  task automatic test_stream();
    do_reset();
    run = 1'b1; inst_ready = 1'b1;
    step();
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL stream_first_run got %b exp 0", inst_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (inst_valid !== 1'b1 || inst_pc !== 10'(4 * i) || inst !== prog[i]) begin
        errs++; $display("FAIL stream_%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", i, inst_valid, inst_pc, inst, 10'(4 * i), prog[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    run = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) begin
        vecs++;
        if (inst_valid !== 1'b1 || inst !== 32'h000010b7 || inst_pc !== 10'h000) begin
          errs++; $display("FAIL stall_%0d got v=%b pc=%h inst=%h exp v=1 pc=000 inst=000010b7", i, inst_valid, inst_pc, inst);
        end
      end
    end
    vecs++; if (imem_addr !== 10'h008) begin errs++; $display("FAIL stall_pc got %h exp 008", imem_addr); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 10'h00C; inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL redir_bubble got %b exp 0", inst_valid); end
    vecs++; if (imem_addr !== 10'h00C) begin errs++; $display("FAIL redir_addr got %h exp 00c", imem_addr); end
    step();
    vecs++;
    if (inst_valid !== 1'b1 || inst_pc !== 10'h00C || inst !== 32'h00000063) begin
      errs++; $display("FAIL redir_target got v=%b pc=%h inst=%h exp v=1 pc=00c inst=00000063", inst_valid, inst_pc, inst);
    end
    step();
    vecs++;
    if (inst_valid !== 1'b1 || inst_pc !== 10'h010 || inst !== 32'h10000004) begin
      errs++; $display("FAIL redir_next got v=%b pc=%h inst=%h exp v=1 pc=010 inst=10000004", inst_valid, inst_pc, inst);
    end
`ifndef IFETCH_ALIGN_CHECK_EN
    redirect_valid = 1'b1; redirect_pc = 10'h00E;
    step();
    redirect_valid = 1'b0;
    vecs++; if (imem_addr !== 10'h00C) begin errs++; $display("FAIL redir_lowbits got %h exp 00c", imem_addr); end
    step();
    vecs++; if (inst_valid !== 1'b1 || inst_pc !== 10'h00C) begin errs++; $display("FAIL redir_lowbits_pc got v=%b pc=%h exp v=1 pc=00c", inst_valid, inst_pc); end
`endif
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 10'h3FC; inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    step();
    vecs++;
    if (inst_valid !== 1'b1 || inst_pc !== 10'h3FC || inst !== 32'hDEADBEEF) begin
      errs++; $display("FAIL wrap_last got v=%b pc=%h inst=%h exp v=1 pc=3fc inst=deadbeef", inst_valid, inst_pc, inst);
    end
    step();
    vecs++;
    if (inst_valid !== 1'b1 || inst_pc !== 10'h000 || inst !== 32'h000010b7) begin
      errs++; $display("FAIL wrap_zero got v=%b pc=%h inst=%h exp v=1 pc=000 inst=000010b7", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_idle_drain();
    do_reset();
    run = 1'b1; inst_ready = 1'b0;
    repeat (3) step();
    run = 1'b0;
    step();
    inst_ready = 1'b1;
    vecs++; if (inst_valid !== 1'b1 || inst_pc !== 10'h000) begin errs++; $display("FAIL idle_head0 got v=%b pc=%h exp v=1 pc=000", inst_valid, inst_pc); end
    step();
    vecs++; if (inst_valid !== 1'b1 || inst_pc !== 10'h004) begin errs++; $display("FAIL idle_head1 got v=%b pc=%h exp v=1 pc=004", inst_valid, inst_pc); end
    step();
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL idle_empty got %b exp 0", inst_valid); end
    step();
    vecs++; if (inst_valid !== 1'b0 || imem_addr !== 10'h008) begin errs++; $display("FAIL idle_nofetch got v=%b addr=%h exp v=0 addr=008", inst_valid, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 10'h010;
    step();
    redirect_valid = 1'b0;
    step();
    vecs++; if (inst_valid !== 1'b0 || imem_addr !== 10'h010) begin errs++; $display("FAIL idle_redir got v=%b addr=%h exp v=0 addr=010", inst_valid, imem_addr); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    run = 1'b1; inst_ready = 1'b0;
    repeat (3) step();
    vecs++; if (inst_valid !== 1'b1 || imem_addr !== 10'h008) begin errs++; $display("FAIL mid_full got v=%b addr=%h exp v=1 addr=008", inst_valid, imem_addr); end
    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h100;
    step();
    rst = 1'b0; redirect_valid = 1'b0; run = 1'b0;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL mid_valid got %b exp 0", inst_valid); end
    vecs++; if (imem_addr !== 10'h000) begin errs++; $display("FAIL mid_addr got %h exp 000", imem_addr); end
    step();
    vecs++; if (inst_valid !== 1'b0 || imem_addr !== 10'h000) begin errs++; $display("FAIL mid_idle got v=%b addr=%h exp v=0 addr=000", inst_valid, imem_addr); end
  endtask

`ifdef IFETCH_ALIGN_CHECK_EN
  task automatic test_align();
    do_reset();
    run = 1'b1; inst_ready = 1'b1;
    repeat (2) step();
    redirect_valid = 1'b1; redirect_pc = 10'h006;
    step();
    redirect_valid = 1'b0;
    vecs++; if (fetch_err !== 1'b1) begin errs++; $display("FAIL align_err got %b exp 1", fetch_err); end
    vecs++; if (inst_valid !== 1'b0 || imem_addr !== 10'h004) begin errs++; $display("FAIL align_flush got v=%b addr=%h exp v=0 addr=004", inst_valid, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 10'h000;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++;
      if (inst_valid !== 1'b0 || fetch_err !== 1'b1) begin
        errs++; $display("FAIL align_hold_%0d got v=%b err=%b exp v=0 err=1", i, inst_valid, fetch_err);
      end
    end
    do_reset();
    vecs++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL align_clear got %b exp 0", fetch_err); end
    run = 1'b1;
    repeat (2) step();
    vecs++; if (inst_valid !== 1'b1 || inst_pc !== 10'h000) begin errs++; $display("FAIL align_resume got v=%b pc=%h exp v=1 pc=000", inst_valid, inst_pc); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    for (int i = 0; i < 4; i++) mem[i] = prog[i];
    mem[255] = 32'hDEADBEEF;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_idle_drain();
    test_reset_midstream();
`ifdef IFETCH_ALIGN_CHECK_EN
    test_align();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
